// File: rtl/rob_tag_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_allocator_pkg
// Description : Global ROB tag definitions shared by the tag allocator slice:
//               boolean constants, reserved "no tag" value, tag width, ROB
//               depth and the allocator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_tag_allocator_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ROB_TAG_WIDTH = 5;
    localparam int ROB_SIZE      = 16;

    // Tag 0 means "no tag"; the first live tag is the one right after it.
    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB  = '0;
    localparam logic [ROB_TAG_WIDTH-1:0] FIRST_TAG_ROB = ZERO_TAG_ROB + 1'b1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/rob_tag_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_allocator_if
// Description : Issue / commit / flush bundle between the decoder + ROB
//               (master) and the tag allocator (slave).
//   in_issue_req     decoder wants a destination tag
//   out_issue_grant  request accepted this cycle
//   out_issue_tag    tag granted (tail pointer)
//   in_commit_valid  ROB retires an entry
//   in_commit_tag    tag being retired
//   out_head_tag     oldest outstanding tag
//   out_count        outstanding tag count
//   out_full/empty   occupancy flags
//   in_misbranch     flush all outstanding tags
//   out_flushing     allocator is in its post-flush blocking window
//   out_order_err    sticky out-of-order / empty commit flag
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_tag_allocator_if #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 5
);
    logic             in_issue_req;
    logic             out_issue_grant;
    logic [TAG_W-1:0] out_issue_tag;
    logic             in_commit_valid;
    logic [TAG_W-1:0] in_commit_tag;
    logic [TAG_W-1:0] out_head_tag;
    logic [CNT_W-1:0] out_count;
    logic             out_full;
    logic             out_empty;
    logic             in_misbranch;
    logic             out_flushing;
    logic             out_order_err;

    modport master (
        output in_issue_req, in_commit_valid, in_commit_tag, in_misbranch,
        input  out_issue_grant, out_issue_tag, out_head_tag, out_count,
               out_full, out_empty, out_flushing, out_order_err
    );

    modport slave (
        input  in_issue_req, in_commit_valid, in_commit_tag, in_misbranch,
        output out_issue_grant, out_issue_tag, out_head_tag, out_count,
               out_full, out_empty, out_flushing, out_order_err
    );
endinterface
`default_nettype wire

// File: rtl/rob_tag_allocator_tag_ptr_inc.sv
`default_nettype none
// ============================================================================
// Module      : tag_ptr_inc
// Description : Combinational wrapping tag increment: ROB_SIZE wraps to the
//               first live tag, every other tag advances by one. Tag 0 is
//               never produced.
//   i_tag  current pointer value
//   o_tag  next pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module tag_ptr_inc
    import rob_tag_allocator_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int ROB_SIZE = 16
) (
    input  wire logic [TAG_W-1:0] i_tag,
    output logic      [TAG_W-1:0] o_tag
);
    localparam logic [TAG_W-1:0] c_LAST_TAG  = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0] c_FIRST_TAG = TAG_W'(FIRST_TAG_ROB);

    assign o_tag = (i_tag == c_LAST_TAG) ? c_FIRST_TAG : (i_tag + TAG_W'(1));
endmodule
`default_nettype wire

// File: rtl/rob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_allocator
// Description : Hands out ROB tags 1..ROB_SIZE to the decoder, enforces
//               in-order retirement and flushes all tags on misbranch.
//   clk   clock
//   rst   synchronous active-high reset (wins over rdy)
//   rdy   global ready; low freezes all state
//   bus   rob_tag_allocator_if.slave issue/commit/flush bundle
// Revision    : 1.0 - initial release
// ============================================================================
module rob_tag_allocator
    import rob_tag_allocator_pkg::*;
#(
    parameter int ROB_SIZE     = rob_tag_allocator_pkg::ROB_SIZE,
    parameter int TAG_W        = rob_tag_allocator_pkg::ROB_TAG_WIDTH,
    parameter int CNT_W        = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             rdy,
    rob_tag_allocator_if.slave    bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TAG_W-1:0] c_FIRST_TAG = TAG_W'(FIRST_TAG_ROB);
    localparam logic [CNT_W-1:0] c_FULL_CNT  = CNT_W'(ROB_SIZE);
    localparam logic [FC_W-1:0]  c_FLUSH_LD  = FC_W'(FLUSH_CYCLES - 1);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    alloc_state_t     r_state;
    logic [FC_W-1:0]  r_flush_cnt;
    logic             r_order_err;

    logic [TAG_W-1:0] w_head_nxt;
    logic [TAG_W-1:0] w_tail_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_grant;
    logic             w_commit_try;
    logic             w_commit_hit;
    logic             w_commit_bad;

    tag_ptr_inc #(.TAG_W(TAG_W), .ROB_SIZE(ROB_SIZE)) u_head_inc (
        .i_tag (r_head),
        .o_tag (w_head_nxt)
    );

    tag_ptr_inc #(.TAG_W(TAG_W), .ROB_SIZE(ROB_SIZE)) u_tail_inc (
        .i_tag (r_tail),
        .o_tag (w_tail_nxt)
    );

    // Occupancy comes from the count, never from pointer equality: head==tail
    // is ambiguous between empty and full.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Full uses the registered count only; a same-cycle commit does not free
    // a slot for this cycle's request.
    assign w_grant = rdy & bus.in_issue_req & ~w_full & (r_state == ST_RUN)
                   & ~bus.in_misbranch;

    // A misbranch discards any same-cycle commit outright, so it is neither
    // retired nor flagged as an ordering error.
    assign w_commit_try = rdy & bus.in_commit_valid & ~bus.in_misbranch;
    assign w_commit_hit = w_commit_try & ~w_empty & (bus.in_commit_tag == r_head);
    assign w_commit_bad = w_commit_try & (w_empty | (bus.in_commit_tag != r_head));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= c_FIRST_TAG;
            r_tail      <= c_FIRST_TAG;
            r_count     <= '0;
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_order_err <= FALSE;
        end else if (rdy) begin
            if (bus.in_misbranch) begin
                r_head      <= c_FIRST_TAG;
                r_tail      <= c_FIRST_TAG;
                r_count     <= '0;
                r_state     <= ST_FLUSH;
                r_flush_cnt <= c_FLUSH_LD;
            end else begin
                if (w_grant) begin
                    r_tail <= w_tail_nxt;
                end
                if (w_commit_hit) begin
                    r_head <= w_head_nxt;
                end
                if (w_commit_bad) begin
                    r_order_err <= TRUE;
                end
                if (w_grant && !w_commit_hit) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_grant && w_commit_hit) begin
                    r_count <= r_count - CNT_W'(1);
                end
                if (r_state == ST_FLUSH) begin
                    if (r_flush_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                    end
                end
            end
        end
    end

    assign bus.out_issue_grant = w_grant;
    assign bus.out_issue_tag   = r_tail;
    assign bus.out_head_tag    = r_head;
    assign bus.out_count       = r_count;
    assign bus.out_full        = w_full;
    assign bus.out_empty       = w_empty;
    assign bus.out_flushing    = (r_state == ST_FLUSH);
    assign bus.out_order_err   = r_order_err;
endmodule
`default_nettype wire

// File: tb/tb_rob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_tag_allocator
// Description : Self-checking bench for rob_tag_allocator: directed vector
//               table, hand-written multi-cycle sequences and randomized
//               traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_tag_allocator;
    localparam int ROB   = 16;
    localparam int TW    = 5;
    localparam int CW    = 5;
    localparam int FLUSH = 1;

    logic clk;
    logic rst;
    logic rdy;

    rob_tag_allocator_if #(.TAG_W(TW), .CNT_W(CW)) bus ();

    rob_tag_allocator #(
        .ROB_SIZE(ROB), .TAG_W(TW), .CNT_W(CW), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the in-flight tags in program order, the next tag to
    // hand out, the sticky error and the remaining blocked cycles.
    int q[$];
    int next_tag;
    bit m_err;
    int flush_left;

    function automatic int m_head();
        return (q.size() > 0) ? q[0] : next_tag;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input bit r, input bit rd, input bit req, input bit cv,
                       input int ctag, input bit mis);
        rst                 = r;
        rdy                 = rd;
        bus.in_issue_req    = req;
        bus.in_commit_valid = cv;
        bus.in_commit_tag   = TW'(ctag);
        bus.in_misbranch    = mis;
    endtask

    task automatic model_update();
        bit g;
        if (rst) begin
            q.delete(); next_tag = 1; m_err = 0; flush_left = 0;
        end else if (rdy) begin
            if (bus.in_misbranch) begin
                q.delete(); next_tag = 1; flush_left = FLUSH;
            end else begin
                g = bus.in_issue_req && (q.size() < ROB) && (flush_left == 0);
                if (bus.in_commit_valid) begin
                    if (q.size() > 0 && int'(bus.in_commit_tag) == q[0]) void'(q.pop_front());
                    else m_err = 1;
                end
                if (g) begin
                    q.push_back(next_tag);
                    next_tag = (next_tag % ROB) + 1;
                end
                if (flush_left > 0) flush_left--;
            end
        end
    endtask

    task automatic check_model(input string nm);
        bit eg;
        eg = rdy && bus.in_issue_req && !bus.in_misbranch && (q.size() < ROB) && (flush_left == 0);
        chk({nm, ".grant"}, 32'(bus.out_issue_grant), 32'(eg));
        chk({nm, ".tag"},   32'(bus.out_issue_tag),   32'(next_tag));
        chk({nm, ".head"},  32'(bus.out_head_tag),    32'(m_head()));
        chk({nm, ".count"}, 32'(bus.out_count),       32'(q.size()));
        chk({nm, ".full"},  32'(bus.out_full),        32'(q.size() == ROB));
        chk({nm, ".empty"}, 32'(bus.out_empty),       32'(q.size() == 0));
        chk({nm, ".flush"}, 32'(bus.out_flushing),    32'(flush_left > 0));
        chk({nm, ".err"},   32'(bus.out_order_err),   32'(m_err));
    endtask

    // Inputs are changed at the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic mcycle(input bit r, input bit rd, input bit req, input bit cv,
                          input int ctag, input bit mis, input string nm);
        drv(r, rd, req, cv, ctag, mis);
        #1;
        check_model(nm);
        tick();
    endtask

    typedef struct {
        bit rst, rdy, req, cv; int ctag; bit mis;
        bit g; int tag, head, cnt; bit full, empty, fl, err;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(bit r, bit rd, bit req, bit cv, int ct, bit mis,
                                bit g, int tag, int head, int cnt,
                                bit full, bit empty, bit fl, bit err);
        vec_t v;
        v.rst = r; v.rdy = rd; v.req = req; v.cv = cv; v.ctag = ct; v.mis = mis;
        v.g = g; v.tag = tag; v.head = head; v.cnt = cnt;
        v.full = full; v.empty = empty; v.fl = fl; v.err = err;
        return v;
    endfunction

    initial begin
        //            rst rdy req cv tag mis | g tag head cnt full empty fl err
        tv[0]  = mk(0, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0, 0);
        tv[1]  = mk(0, 1, 1, 0, 0, 0,   1, 2, 1, 1, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 1, 0, 0, 0,   1, 3, 1, 2, 0, 0, 0, 0);
        tv[3]  = mk(0, 1, 0, 0, 0, 0,   0, 4, 1, 3, 0, 0, 0, 0);
        tv[4]  = mk(0, 1, 0, 1, 1, 0,   0, 4, 1, 3, 0, 0, 0, 0);
        tv[5]  = mk(0, 1, 0, 1, 3, 0,   0, 4, 2, 2, 0, 0, 0, 0);
        tv[6]  = mk(0, 1, 1, 1, 2, 0,   1, 4, 2, 2, 0, 0, 0, 1);
        tv[7]  = mk(0, 0, 1, 1, 3, 1,   0, 5, 3, 2, 0, 0, 0, 1);
        tv[8]  = mk(0, 0, 1, 0, 0, 0,   0, 5, 3, 2, 0, 0, 0, 1);
        tv[9]  = mk(0, 1, 1, 1, 3, 1,   0, 5, 3, 2, 0, 0, 0, 1);
        tv[10] = mk(0, 1, 1, 0, 0, 0,   0, 1, 1, 0, 0, 1, 1, 1);
        tv[11] = mk(0, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0, 1);
        tv[12] = mk(1, 1, 0, 0, 0, 0,   0, 2, 1, 1, 0, 0, 0, 1);
        tv[13] = mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0, 0);
        tv[14] = mk(0, 1, 0, 1, 1, 0,   0, 1, 1, 0, 0, 1, 0, 0);
        tv[15] = mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0, 1);

        drv(1, 1, 0, 0, 0, 0);
        repeat (2) tick();

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drv(tv[i].rst, tv[i].rdy, tv[i].req, tv[i].cv, tv[i].ctag, tv[i].mis);
            #1;
            chk({nm, ".grant"}, 32'(bus.out_issue_grant), 32'(tv[i].g));
            chk({nm, ".tag"},   32'(bus.out_issue_tag),   32'(tv[i].tag));
            chk({nm, ".head"},  32'(bus.out_head_tag),    32'(tv[i].head));
            chk({nm, ".count"}, 32'(bus.out_count),       32'(tv[i].cnt));
            chk({nm, ".full"},  32'(bus.out_full),        32'(tv[i].full));
            chk({nm, ".empty"}, 32'(bus.out_empty),       32'(tv[i].empty));
            chk({nm, ".flush"}, 32'(bus.out_flushing),    32'(tv[i].fl));
            chk({nm, ".err"},   32'(bus.out_order_err),   32'(tv[i].err));
            tick();
        end

        // ---------------- fill to full, wrap on commit ----------------
        mcycle(1, 1, 0, 0, 0, 0, "rstA");
        for (int i = 0; i < ROB; i++) begin
            drv(0, 1, 1, 0, 0, 0);
            #1;
            chk("fill.grant", 32'(bus.out_issue_grant), 32'd1);
            chk("fill.tag",   32'(bus.out_issue_tag),   32'(i + 1));
            check_model("fill");
            tick();
        end
        drv(0, 1, 1, 0, 0, 0);
        #1;
        chk("full.flag",  32'(bus.out_full),        32'd1);
        chk("full.grant", 32'(bus.out_issue_grant), 32'd0);
        tick();
        drv(0, 1, 1, 1, 1, 0);
        #1;
        chk("fullcommit.grant", 32'(bus.out_issue_grant), 32'd0);
        tick();
        drv(0, 1, 1, 0, 0, 0);
        #1;
        chk("wrap.grant", 32'(bus.out_issue_grant), 32'd1);
        chk("wrap.tag",   32'(bus.out_issue_tag),   32'd1);
        tick();
        drv(0, 1, 0, 0, 0, 0);
        #1;
        chk("wrap.count", 32'(bus.out_count), 32'd16);
        check_model("wrap");

        // ------- simultaneous commit+issue, bad commit, misbranch -------
        mcycle(1, 1, 0, 0, 0, 0, "rstB");
        for (int i = 0; i < 6; i++) mcycle(0, 1, 1, 0, 0, 0, "b.issue");
        for (int i = 1; i <= 4; i++) mcycle(0, 1, 0, 1, i, 0, "b.commit");
        drv(0, 1, 1, 1, 5, 0);
        #1;
        chk("sim.head_pre", 32'(bus.out_head_tag),    32'd5);
        chk("sim.grant",    32'(bus.out_issue_grant), 32'd1);
        chk("sim.tag",      32'(bus.out_issue_tag),   32'd7);
        tick();
        drv(0, 1, 0, 1, 9, 0);
        #1;
        chk("sim.head", 32'(bus.out_head_tag),  32'd6);
        chk("sim.tail", 32'(bus.out_issue_tag), 32'd8);
        chk("sim.cnt",  32'(bus.out_count),     32'd2);
        tick();
        drv(0, 1, 0, 0, 0, 0);
        #1;
        chk("bad.err",  32'(bus.out_order_err), 32'd1);
        chk("bad.head", 32'(bus.out_head_tag),  32'd6);
        check_model("bad");
        for (int i = 0; i < 8; i++) mcycle(0, 1, 1, 0, 0, 0, "b.issue2");
        drv(0, 1, 1, 1, 6, 1);
        #1;
        chk("mis.cnt_pre", 32'(bus.out_count),       32'd10);
        chk("mis.grant",   32'(bus.out_issue_grant), 32'd0);
        tick();
        drv(0, 1, 1, 0, 0, 0);
        #1;
        chk("mis.cnt",   32'(bus.out_count),       32'd0);
        chk("mis.head",  32'(bus.out_head_tag),    32'd1);
        chk("mis.tail",  32'(bus.out_issue_tag),   32'd1);
        chk("mis.flush", 32'(bus.out_flushing),    32'd1);
        chk("mis.deny",  32'(bus.out_issue_grant), 32'd0);
        tick();
        drv(0, 1, 1, 0, 0, 0);
        #1;
        chk("post.grant", 32'(bus.out_issue_grant), 32'd1);
        chk("post.tag",   32'(bus.out_issue_tag),   32'd1);
        check_model("post");
        tick();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            bit r, rd, req, cv, mis;
            int ct;
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 9) != 0);
            req = ($urandom_range(0, 9) < 6);
            mis = ($urandom_range(0, 39) == 0);
            cv  = !mis && ($urandom_range(0, 1) == 1);
            ct  = ($urandom_range(0, 9) < 8) ? m_head() : int'($urandom_range(0, 31));
            mcycle(r, rd, req, cv, ct, mis, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rob_tag_allocator.md
Name: rob_tag_allocator

Overview:
- Scheduler for rename-tag ownership in the register status file. It hands out ROB tags to the decoder for destination registers, enforces in-order retirement of those tags, and flushes all outstanding tags on misbranch.
- Sits between fetcher/decoder (issue side) and ROB (commit side).
- Its grant and tag drive the register file's destination-write enable and destination ROB tag.
- Tag 0 is reserved as "no tag"; live tags are 1..ROB_SIZE.

Parameters:
- ROB_SIZE, 16, number of allocatable tags (tags 1..ROB_SIZE).
- TAG_W, 5, ROB tag width; must satisfy 2^TAG_W > ROB_SIZE.
- CNT_W, 5, occupancy counter width; must hold 0..ROB_SIZE.
- FLUSH_CYCLES, 1, cycles issue stays blocked after a misbranch.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- in_issue_req  in  1  decoder requests a destination tag this cycle.
- out_issue_grant  out  1  request accepted this cycle (combinational).
- out_issue_tag  out  TAG_W  tag granted; equals tail pointer, valid when grant=1.
- in_commit_valid  in  1  ROB retires an entry this cycle.
- in_commit_tag  in  TAG_W  tag being retired.
- out_head_tag  out  TAG_W  oldest outstanding tag.
- out_count  out  CNT_W  outstanding tag count.
- out_full  out  1  count == ROB_SIZE.
- out_empty  out  1  count == 0.
- in_misbranch  in  1  ROB misbranch flush.
- out_flushing  out  1  state == FLUSH.
- out_order_err  out  1  sticky: commit tag != head, or commit while empty.

Behaviour:
- Reset (rst=1 at posedge): head=1, tail=1, count=0, state=RUN, flush counter=0, order_err=0. Resulting outputs: grant=0, issue_tag=1, head_tag=1, count=0, full=0, empty=1, flushing=0. rst has priority over rdy.
- States:
  - RUN: normal operation.
  - FLUSH: issue blocked; counts FLUSH_CYCLES cycles, then returns to RUN.
- Grant: out_issue_grant = rdy & in_issue_req & !out_full & state==RUN & !in_misbranch.
  - Full is taken from the registered count, with no same-cycle commit bypass. A commit in the same cycle as full does not allow a grant that cycle.
- Issue: on grant, tail advances by one at the posedge. Tag ROB_SIZE wraps to 1; tag 0 is never produced.
- Commit: accepted when rdy & in_commit_valid & !empty & in_commit_tag==head & !in_misbranch. Head then advances with the same wrap rule.
  - A commit with a mismatched tag or while empty is ignored and sets order_err.
  - order_err is cleared only by rst.
- Count: +1 on grant only, -1 on accepted commit only, unchanged when both or neither occur. Simultaneous grant and commit advance both pointers.
- Misbranch (rdy=1): head=tail=1, count=0, state=FLUSH, flush counter=FLUSH_CYCLES-1. Same-cycle issue and commit are discarded; misbranch wins. A misbranch while already in FLUSH restarts the counter.
- FLUSH: decrement the counter each rdy cycle; move to RUN when it reaches 0. Commits while in FLUSH are checked normally (empty, so they set order_err).
- rdy=0: no state changes, grant=0, commit ignored (no error flagged).
- Invariant: count == (tail - head) mod ROB_SIZE, except when full, where head == tail with count=ROB_SIZE. full/empty are derived from count, not from pointer equality.

Decomposition:
- Shared constants package/include: TRUE/FALSE, ZERO_TAG_ROB, ROB_TAG_WIDTH, ROB_SIZE. Reuse the existing global definitions; no local redefinition.
- One natural sub-module, tag_ptr_inc: combinational wrap increment (ROB_SIZE→1, else +1). Instantiated twice, for head and tail.
- Everything else stays flat in rob_tag_allocator.

Test Plan:
- Reset then 3 requests on consecutive cycles → grants with tags 1,2,3; count=3; head_tag=1; empty=0.
- Issue 16 with no commits → tags 1..16, full=1; 17th request gets grant=0. Commit tag 1 and request in the same cycle → grant=0 that cycle, granted with tag 1 (wrapped) next cycle; count back to 16.
- Count=2 (head=5, tail=7); simultaneous commit tag 5 and request → grant tag 7; next cycle head=6, tail=8, count=2.
- Commit tag 9 while head=5 → ignored; head stays 5; order_err=1 and stays set until rst.
- Misbranch with count=10 plus same-cycle request and commit → no grant; next cycle count=0, head=tail=1, flushing=1. Request in that cycle denied; following cycle grant with tag 1.
- rdy=0 for 4 cycles with requests and commits asserted → no grants, pointers and count unchanged. rst asserted mid-sequence → reset values next cycle.
